// File: rtl/riscv_pkg.sv
// Shared types and constants for the decode/execute boundary of the pipeline.
// The id_ex_t field widths match the default widths of id_ex_operand_stage.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_OP_W  = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'b1001;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm;
        logic                 alu_src;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
    } id_ex_t;

endpackage

// File: rtl/forward_unit.sv
// Operand-forwarding select logic: picks the youngest in-flight producer of
// each EX-stage source register, never forwarding writes to x0.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    output fwd_sel_e                  fwd_a_sel,
    output fwd_sel_e                  fwd_b_sel
);

    logic exmem_live;
    logic memwb_live;

    assign exmem_live = exmem_reg_write && (exmem_rd != '0);
    assign memwb_live = memwb_reg_write && (memwb_rd != '0);

    // EX/MEM holds the younger result, so it is checked first.
    always_comb begin
        fwd_a_sel = FWD_REG;
        if (exmem_live && (exmem_rd == rs1)) begin
            fwd_a_sel = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rs1)) begin
            fwd_a_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b_sel = FWD_REG;
        if (exmem_live && (exmem_rd == rs2)) begin
            fwd_b_sel = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rs2)) begin
            fwd_b_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding into the ALU operands and
// load-use hazard detection that stalls the front end for one bubble.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rd1,
    input  logic [DATA_WIDTH-1:0]     id_rd2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_alu_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_wdata,
    output logic                      stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write
);

    id_ex_t   ex_q;
    id_ex_t   id_next;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    always_comb begin
        id_next           = '0;
        id_next.valid     = id_valid;
        id_next.rs1       = id_rs1;
        id_next.rs2       = id_rs2;
        id_next.rd        = id_rd;
        id_next.rd1       = id_rd1;
        id_next.rd2       = id_rd2;
        id_next.imm       = id_imm;
        id_next.alu_src   = id_alu_src;
        id_next.alu_op    = id_alu_op;
        id_next.mem_read  = id_mem_read;
        id_next.mem_write = id_mem_write;
        id_next.reg_write = id_reg_write;
    end

    // A load in EX cannot forward its data yet; hold decode for one cycle.
    always_comb begin
        stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != ZERO_REG)
                && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    end

    // An all-zero record is the bubble: invalid, no side effects, AND opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush || stall) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_next;
        end
    end

    forward_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_forward_unit (
        .rs1             (ex_q.rs1),
        .rs2             (ex_q.rs2),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
    );

    always_comb begin
        unique case (fwd_a_sel)
            FWD_EXMEM: fwd_a = exmem_alu_result;
            FWD_MEMWB: fwd_a = memwb_wdata;
            default:   fwd_a = ex_q.rd1;
        endcase
    end

    always_comb begin
        unique case (fwd_b_sel)
            FWD_EXMEM: fwd_b = exmem_alu_result;
            FWD_MEMWB: fwd_b = memwb_wdata;
            default:   fwd_b = ex_q.rd2;
        endcase
    end

    // Stores always need the register value, even when SrcB is the immediate.
    assign SrcA          = fwd_a;
    assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign Operation     = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage: expected EX contents are
// queued when an instruction is offered to decode and checked a cycle later.
module tb_id_ex_operand_stage;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  op;
        logic        mr;
        logic        mw;
        logic        rw;
    } instr_t;

    typedef struct packed {
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwdata;
    } fwd_t;

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] store;
        logic [3:0]  op;
        logic        valid;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic [31:0] id_rd1 = '0;
    logic [31:0] id_rd2 = '0;
    logic [31:0] id_imm = '0;
    logic        id_alu_src = 1'b0;
    logic [3:0]  id_alu_op = '0;
    logic        id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0;
    logic        id_reg_write = 1'b0;
    logic        exmem_reg_write = 1'b0;
    logic [4:0]  exmem_rd = '0;
    logic [31:0] exmem_alu_result = '0;
    logic        memwb_reg_write = 1'b0;
    logic [4:0]  memwb_rd = '0;
    logic [31:0] memwb_wdata = '0;
    logic        stall;
    logic        ex_valid;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;

    exp_t   scoreboard[$];
    instr_t last_captured;
    int     compared = 0;
    int     mismatched = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .id_rd1           (id_rd1),
        .id_rd2           (id_rd2),
        .id_imm           (id_imm),
        .id_alu_src       (id_alu_src),
        .id_alu_op        (id_alu_op),
        .id_mem_read      (id_mem_read),
        .id_mem_write     (id_mem_write),
        .id_reg_write     (id_reg_write),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_rd         (exmem_rd),
        .exmem_alu_result (exmem_alu_result),
        .memwb_reg_write  (memwb_reg_write),
        .memwb_rd         (memwb_rd),
        .memwb_wdata      (memwb_wdata),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .SrcA             (SrcA),
        .SrcB             (SrcB),
        .Operation        (Operation),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_reg_write     (ex_reg_write)
    );

    function automatic logic [31:0] fwdVal(input logic [4:0] rs, input logic [31:0] rv, input fwd_t f);
        if (f.exw && f.exrd != 5'd0 && f.exrd == rs) return f.exres;
        if (f.mww && f.mwrd != 5'd0 && f.mwrd == rs) return f.mwdata;
        return rv;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            cmp({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = scoreboard.pop_front();
        cmp({tag, "_SrcA"}, SrcA, e.srca);
        cmp({tag, "_SrcB"}, SrcB, e.srcb);
        cmp({tag, "_store"}, ex_store_data, e.store);
        cmp({tag, "_Operation"}, {28'd0, Operation}, {28'd0, e.op});
        cmp({tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        cmp({tag, "_ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
        cmp({tag, "_ctrl"}, {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, {29'd0, e.mr, e.mw, e.rw});
    endtask

    // Checks the previous instruction, then offers a new one to the stage.
    task automatic applyStimulus(input string tag, input instr_t i, input fwd_t f,
                                 input logic fl, input logic rst);
        logic   exp_stall;
        instr_t cap;
        exp_t   e;
        @(negedge clk);
        checkOutput(tag);
        reset            = rst;
        flush            = fl;
        id_valid         = i.valid;
        id_rs1           = i.rs1;
        id_rs2           = i.rs2;
        id_rd            = i.rd;
        id_rd1           = i.rd1;
        id_rd2           = i.rd2;
        id_imm           = i.imm;
        id_alu_src       = i.alu_src;
        id_alu_op        = i.op;
        id_mem_read      = i.mr;
        id_mem_write     = i.mw;
        id_reg_write     = i.rw;
        exmem_reg_write  = f.exw;
        exmem_rd         = f.exrd;
        exmem_alu_result = f.exres;
        memwb_reg_write  = f.mww;
        memwb_rd         = f.mwrd;
        memwb_wdata      = f.mwdata;
        exp_stall = i.valid && last_captured.valid && last_captured.mr && (last_captured.rd != 5'd0)
                    && (last_captured.rd == i.rs1 || last_captured.rd == i.rs2);
        #1;
        cmp({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        cap = (rst || fl || exp_stall) ? '0 : i;
        e.srca  = fwdVal(cap.rs1, cap.rd1, f);
        e.store = fwdVal(cap.rs2, cap.rd2, f);
        e.srcb  = cap.alu_src ? cap.imm : e.store;
        e.op    = cap.op;
        e.valid = cap.valid;
        e.rd    = cap.rd;
        e.mr    = cap.mr;
        e.mw    = cap.mw;
        e.rw    = cap.rw;
        scoreboard.push_back(e);
        last_captured = cap;
    endtask

    initial begin
        instr_t nop, add_i, or_i, x0_i, ld_i, sub_i, lui_i, ld2_i, dep2_i, xor_i, eq_i, ld3_i, dep3_i;
        fwd_t   nf, f2, f3, f4, f7, f8, f11;
        nop   = '0;
        nf    = '0;
        add_i = '{1'b1, 5'd1, 5'd2, 5'd10, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};
        or_i  = '{1'b1, 5'd3, 5'd6, 5'd11, 32'd1, 32'd9, 32'd0, 1'b0, ALU_OR, 1'b0, 1'b0, 1'b1};
        x0_i  = '{1'b1, 5'd0, 5'd5, 5'd12, 32'd0, 32'd3, 32'd0, 1'b0, ALU_AND, 1'b0, 1'b0, 1'b1};
        ld_i  = '{1'b1, 5'd7, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1};
        sub_i = '{1'b1, 5'd8, 5'd4, 5'd12, 32'd3, 32'h99, 32'd0, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b1};
        lui_i = '{1'b1, 5'd2, 5'd9, 5'd0, 32'd1, 32'd0, 32'hFFFFF000, 1'b1, ALU_LUI, 1'b0, 1'b1, 1'b0};
        ld2_i = '{1'b1, 5'd1, 5'd0, 5'd6, 32'h40, 32'd0, 32'd4, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1};
        dep2_i= '{1'b1, 5'd6, 5'd2, 5'd7, 32'd2, 32'd3, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};
        xor_i = '{1'b1, 5'd13, 5'd14, 5'd15, 32'h77, 32'h88, 32'd0, 1'b0, ALU_XOR, 1'b0, 1'b0, 1'b1};
        eq_i  = '{1'b1, 5'd16, 5'd17, 5'd18, 32'h11, 32'h22, 32'd0, 1'b0, ALU_EQ, 1'b0, 1'b0, 1'b1};
        ld3_i = '{1'b1, 5'd2, 5'd0, 5'd5, 32'h80, 32'd0, 32'd0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1};
        dep3_i= '{1'b1, 5'd5, 5'd3, 5'd20, 32'h30, 32'h31, 32'd0, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b1};
        f2  = '{1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20};
        f3  = '{1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20};
        f4  = '{1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hAA};
        f7  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1234};
        f8  = '{1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0};
        f11 = '{1'b1, 5'd13, 32'hCAFE, 1'b1, 5'd14, 32'hBEEF};
        last_captured = '0;

        $display("[TB] start");
        repeat (2) @(posedge clk);
        scoreboard.push_back('0);
        applyStimulus("reset_state", add_i, nf, 1'b0, 1'b0);
        applyStimulus("add", or_i, f2, 1'b0, 1'b0);
        applyStimulus("fwd_exmem_prio", or_i, f3, 1'b0, 1'b0);
        applyStimulus("fwd_memwb", x0_i, f4, 1'b0, 1'b0);
        applyStimulus("x0_no_fwd", ld_i, nf, 1'b0, 1'b0);
        applyStimulus("load", sub_i, nf, 1'b0, 1'b0);
        applyStimulus("bubble", sub_i, f7, 1'b0, 1'b0);
        applyStimulus("held_capture", lui_i, f8, 1'b0, 1'b0);
        applyStimulus("imm_store", ld2_i, nf, 1'b0, 1'b0);
        applyStimulus("load2", dep2_i, nf, 1'b1, 1'b0);
        applyStimulus("flush_stall", xor_i, f11, 1'b0, 1'b0);
        applyStimulus("fwd_both", eq_i, nf, 1'b0, 1'b1);
        applyStimulus("reset_mid", ld3_i, nf, 1'b0, 1'b0);
        applyStimulus("load3", dep3_i, nf, 1'b0, 1'b1);
        applyStimulus("reset_stall", dep3_i, nf, 1'b0, 1'b0);
        applyStimulus("after_reset", nop, nf, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
